// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: reset defaults, instruction width and the IF/ID bundle.
package fetch_stage_pkg;

    localparam int unsigned INSTR_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]            pc;
        logic [INSTR_WIDTH-1:0] instruction;
        logic                   valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// 32-bit program counter register with synchronous reset and load enable.
module fetch_stage_pc_register #(
    parameter logic [31:0] ResetValue = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_en_i,
    input  logic [31:0] load_value_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= ResetValue;
        end else if (load_en_i) begin
            pc_q <= load_value_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register, branch/freeze/flush control, fetch counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    input  logic        flush,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pc_load;
    if_id_t      if_id_q, if_id_d, if_id_bubble;
    logic [31:0] fetch_count_q, fetch_count_d;

    fetch_stage_pc_register #(
        .ResetValue(RESET_PC)
    ) u_pc_register (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_en_i   (pc_load),
        .load_value_i(pc_next),
        .pc_o        (pc)
    );

    assign pc_plus4     = pc + 32'd4;
    assign if_id_bubble = '{pc: 32'd0, instruction: NOP_WORD, valid: 1'b0};

    // Branch beats freeze; flush only ever clears IF/ID, it never touches the PC.
    always_comb begin
        pc_load       = 1'b1;
        pc_next       = pc_plus4;
        if_id_d       = if_id_q;
        fetch_count_d = fetch_count_q;
        if (branch_taken) begin
            pc_next = {branch_address[31:2], 2'b00};
            if_id_d = if_id_bubble;
        end else if (freeze) begin
            pc_load = 1'b0;
            if (flush) begin
                if_id_d = if_id_bubble;
            end
        end else if (flush) begin
            if_id_d = if_id_bubble;
        end else begin
            if_id_d       = '{pc: pc_plus4, instruction: imem_instruction, valid: 1'b1};
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q       <= if_id_bubble;
            fetch_count_q <= 32'd0;
        end else begin
            if_id_q       <= if_id_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_address   = pc;
    assign id_pc          = if_id_q.pc;
    assign id_instruction = if_id_q.instruction;
    assign id_valid       = if_id_q.valid;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        flush;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic [31:0] fetch_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] mem [64];

    fetch_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .flush           (flush),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction),
        .id_valid        (id_valid),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // Low 256 bytes come from the table; anything else returns a scrambled address.
    always_comb begin
        imem_instruction = imem_address ^ 32'hA5A5_0000;
        if (imem_address[31:8] == 24'd0) begin
            imem_instruction = mem[imem_address[7:2]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] addr, input logic [31:0] pc4,
                               input logic [31:0] instr, input logic valid,
                               input logic [31:0] cnt);
        check_val({tag, ".imem_address"}, imem_address, addr);
        check_val({tag, ".id_pc"}, id_pc, pc4);
        check_val({tag, ".id_instruction"}, id_instruction, instr);
        check_val({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, valid});
        check_val({tag, ".fetch_count"}, fetch_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hE000_0000 | i;
        end
        mem[0] = 32'hE3A0_0014;
        mem[1] = 32'hE3A0_1A01;

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'd0; flush = 1'b0;
        step();
        step();
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        rst = 1'b0;
        step();
        check_state("seq1", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 32'd1);
        step();
        check_state("seq2", 32'h8, 32'h8, 32'hE3A0_1A01, 1'b1, 32'd2);
        step();
        check_state("seq3", 32'hC, 32'hC, 32'hE000_0002, 1'b1, 32'd3);
        step();
        check_state("seq4", 32'h10, 32'h10, 32'hE000_0003, 1'b1, 32'd4);

        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("freeze", 32'h10, 32'h10, 32'hE000_0003, 1'b1, 32'd4);
        end
        freeze = 1'b0;
        step();
        check_state("unfreeze", 32'h14, 32'h14, 32'hE000_0004, 1'b1, 32'd5);

        branch_taken = 1'b1; branch_address = 32'h66;
        step();
        check_state("branch", 32'h64, 32'h0, 32'h0, 1'b0, 32'd5);
        branch_taken = 1'b0;
        step();
        check_state("branch_tgt", 32'h68, 32'h68, 32'hE000_0019, 1'b1, 32'd6);

        freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h90;
        step();
        check_state("br_frz", 32'h90, 32'h0, 32'h0, 1'b0, 32'd6);
        branch_taken = 1'b0;
        step();
        check_state("br_frz_hold", 32'h90, 32'h0, 32'h0, 1'b0, 32'd6);
        freeze = 1'b0;
        step();
        check_state("br_frz_tgt", 32'h94, 32'h94, 32'hE000_0024, 1'b1, 32'd7);

        branch_taken = 1'b1; branch_address = 32'h20;
        step();
        branch_taken = 1'b0; flush = 1'b1;
        step();
        check_state("flush", 32'h24, 32'h0, 32'h0, 1'b0, 32'd7);
        flush = 1'b0;
        step();
        check_state("post_flush", 32'h28, 32'h28, 32'hE000_0009, 1'b1, 32'd8);

        freeze = 1'b1; flush = 1'b1;
        step();
        check_state("frz_flush", 32'h28, 32'h0, 32'h0, 1'b0, 32'd8);
        freeze = 1'b0; flush = 1'b0;
        step();
        check_state("frz_flush_res", 32'h2C, 32'h2C, 32'hE000_000A, 1'b1, 32'd9);

        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFE;
        step();
        check_state("wrap_br", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd9);
        branch_taken = 1'b0;
        step();
        check_state("wrap1", 32'h0, 32'h0, 32'h5A5A_FFFC, 1'b1, 32'd10);
        step();
        check_state("wrap2", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 32'd11);

        rst = 1'b1;
        step();
        check_state("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0;
        step();
        check_state("midrst_run", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 32'd1);

        rst = 1'b1; freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h40;
        step();
        check_state("rst_over_br", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
